// File: rtl/interval_timer_pkg.sv
// -----------------------------------------------------------------------------
// interval_timer_pkg
//   Shared definitions for the interval timer slice.
//   - TMR_DEFAULT_W : default width of the count and reload values.
//   - tmr_state_e   : control FSM encoding (IDLE, RUN).
//   - tmr_state_name: helper that maps a state to a short printable tag.
// -----------------------------------------------------------------------------
package interval_timer_pkg;

   localparam int unsigned TMR_DEFAULT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tmr_state_e;

   function automatic string tmr_state_name(input tmr_state_e s);
      case (s)
         IDLE:    return "IDLE";
         RUN:     return "RUN";
         default: return "????";
      endcase
   endfunction

endpackage : interval_timer_pkg

// File: rtl/tmr_downcnt.sv
// -----------------------------------------------------------------------------
// tmr_downcnt
//   Loadable W-bit down-counter that saturates at zero.
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous active-high reset, clears the count
//     load       : when high, count takes load_val (load wins over dec_en)
//     load_val   : value written on load
//     dec_en     : when high and count is non-zero, count decrements by one
//     count      : current count
//     zero       : high while count == 0
// -----------------------------------------------------------------------------
module tmr_downcnt
   import interval_timer_pkg::*;
#(
   parameter int unsigned W = TMR_DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec_en,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         is_zero;

   assign is_zero = (count_q == '0);

   // The zero guard keeps the counter from wrapping even if a caller
   // asserts dec_en at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec_en && !is_zero) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = is_zero;

endmodule : tmr_downcnt

// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//   Programmable interval timer with one-shot and periodic modes.
//   Ports:
//     CK    : clock, all state updates on the rising edge
//     CLR   : asynchronous active-high reset
//     D     : reload value, captured into the reload register when LD=1
//     LD    : reload register write strobe (either state)
//     START : load the count from the reload value and enter RUN
//     STOP  : abort to IDLE, count held, no expiry pulse (beats START/expiry)
//     EN    : tick qualifier; the count only moves on EN=1 cycles in RUN
//     MODE  : 0 = one-shot, 1 = periodic; sampled at each expiry
//     Q     : current count
//     Z     : registered expiry pulse, one CK cycle per expiry
//     BUSY  : high while the FSM is in RUN (this is the FSM state bit)
//
//   An expiry is an EN=1 cycle in RUN with Q already at zero, so the period
//   in periodic mode is reload+1 enabled cycles. Z appears on the cycle after
//   the expiry edge is decided, i.e. it is registered alongside the reload.
// -----------------------------------------------------------------------------
module interval_timer
   import interval_timer_pkg::*;
#(
   parameter int unsigned W = TMR_DEFAULT_W
) (
   input  logic         CK,
   input  logic         CLR,
   input  logic [W-1:0] D,
   input  logic         LD,
   input  logic         START,
   input  logic         STOP,
   input  logic         EN,
   input  logic         MODE,
   output logic [W-1:0] Q,
   output logic         Z,
   output logic         BUSY
);

   tmr_state_e   state_q, state_d;
   logic [W-1:0] reload_q, reload_d;
   logic         z_q, z_d;

   logic         cnt_load;
   logic [W-1:0] cnt_load_val;
   logic         cnt_dec;
   logic [W-1:0] cnt_value;
   logic         cnt_zero;

   // ---------------------------------------------------------------------------
   // Next-state / datapath control.
   // Priority: STOP > START > counting. LD is independent of all of them and
   // only touches the reload register; START with LD in the same cycle takes
   // the fresh D so software can load-and-go in one write.
   // An expiry reloads from the reload register's current contents, so an LD
   // issued during a count only shows up at the following reload.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      reload_d     = reload_q;
      z_d          = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = reload_q;
      cnt_dec      = 1'b0;

      if (LD) begin
         reload_d = D;
      end

      if (STOP) begin
         state_d = IDLE;
      end else if (START) begin
         cnt_load     = 1'b1;
         cnt_load_val = LD ? D : reload_q;
         state_d      = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (EN) begin
                  if (!cnt_zero) begin
                     cnt_dec = 1'b1;
                  end else begin
                     z_d = 1'b1;
                     if (MODE) begin
                        cnt_load = 1'b1;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            default: begin
               // IDLE: count held, EN ignored.
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         state_q  <= IDLE;
         reload_q <= '0;
         z_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
         z_q      <= z_d;
      end
   end

   tmr_downcnt #(
      .W (W)
   ) u_downcnt (
      .clk      (CK),
      .rst      (CLR),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec_en   (cnt_dec),
      .count    (cnt_value),
      .zero     (cnt_zero)
   );

   assign Q    = cnt_value;
   assign Z    = z_q;
   assign BUSY = (state_q == RUN);

endmodule : interval_timer
